// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage sequencer:
// opcode map, FSM state encoding and the decoded opcode class.
package alu_pkg;

  // Two-operand group, four opcode variants per operation
  localparam logic [7:0] OP_ADD_LO  = 8'h88;
  localparam logic [7:0] OP_ADD_HI  = 8'h8B;
  localparam logic [7:0] OP_SUB_LO  = 8'h8C;
  localparam logic [7:0] OP_SUB_HI  = 8'h8F;
  localparam logic [7:0] OP_MUL_LO  = 8'h90;
  localparam logic [7:0] OP_MUL_HI  = 8'h93;
  localparam logic [7:0] OP_LOG_LO  = 8'h94;  // and / or / xor
  localparam logic [7:0] OP_LOG_HI  = 8'h9F;

  // Bit set/clear group
  localparam logic [7:0] OP_BIT_LO  = 8'h60;
  localparam logic [7:0] OP_BIT_HI  = 8'h6F;

  // Single-operand group
  localparam logic [7:0] OP_DEC     = 8'h01;
  localparam logic [7:0] OP_INC     = 8'h02;
  localparam logic [7:0] OP_NOT     = 8'h03;
  localparam logic [7:0] OP_SETC    = 8'h04;
  localparam logic [7:0] OP_CLRC    = 8'h05;
  localparam logic [7:0] OP_RL      = 8'h06;
  localparam logic [7:0] OP_RR      = 8'h07;
  localparam logic [7:0] OP_RLC     = 8'h08;
  localparam logic [7:0] OP_RRC     = 8'h09;
  localparam logic [7:0] OP_SWAP    = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB_L = 2'd2,
    WB_H = 2'd3
  } state_e;

  typedef struct packed {
    logic legal;
    logic has_wb;
    logic is_mul;
    logic upd_c;
    logic upd_z;
    logic upd_s;
    logic force_c_val;
    logic force_c;
  } op_class_t;

  function automatic logic in_range(input logic [7:0] v,
                                    input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/alu_exec_if.sv
// Request and writeback handshakes of the execute stage.
// master: issuing/consuming side; slave: the sequencer.
interface alu_exec_if #(parameter int DST_W = 4);

  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_op;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [DST_W-1:0] req_dst;

  logic             wb_valid;
  logic             wb_ready;
  logic [DST_W-1:0] wb_addr;
  logic [7:0]       wb_data;

  modport master (
    output req_valid, req_op, req_a, req_b, req_dst, wb_ready,
    input  req_ready, wb_valid, wb_addr, wb_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_dst, wb_ready,
    output req_ready, wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_exec_decode.sv
// Combinational opcode -> class decoder. Unknown opcodes decode to
// all-zero (illegal, no writeback, no flag effect).
module alu_exec_decode
  import alu_pkg::*;
(
  input  logic [7:0] op_i,
  output op_class_t  cls_o
);

  // Classify the opcode by range first, then by exact single-operand code
  always_comb begin
    cls_o = '0;
    if (in_range(op_i, OP_ADD_LO, OP_ADD_HI)) begin
      cls_o.legal  = 1'b1;
      cls_o.has_wb = 1'b1;
      cls_o.upd_c  = 1'b1;
      cls_o.upd_z  = 1'b1;
    end else if (in_range(op_i, OP_SUB_LO, OP_SUB_HI)) begin
      cls_o.legal  = 1'b1;
      cls_o.has_wb = 1'b1;
      cls_o.upd_z  = 1'b1;
      cls_o.upd_s  = 1'b1;
    end else if (in_range(op_i, OP_MUL_LO, OP_MUL_HI)) begin
      cls_o.legal  = 1'b1;
      cls_o.has_wb = 1'b1;
      cls_o.is_mul = 1'b1;
      cls_o.upd_z  = 1'b1;
    end else if (in_range(op_i, OP_LOG_LO, OP_LOG_HI) ||
                 in_range(op_i, OP_BIT_LO, OP_BIT_HI)) begin
      cls_o.legal  = 1'b1;
      cls_o.has_wb = 1'b1;
      cls_o.upd_z  = 1'b1;
    end else begin
      case (op_i)
        OP_DEC: begin
          cls_o.legal  = 1'b1;
          cls_o.has_wb = 1'b1;
          cls_o.upd_z  = 1'b1;
          cls_o.upd_s  = 1'b1;
        end
        OP_INC, OP_RLC, OP_RRC: begin
          cls_o.legal  = 1'b1;
          cls_o.has_wb = 1'b1;
          cls_o.upd_c  = 1'b1;
          cls_o.upd_z  = 1'b1;
        end
        OP_NOT, OP_RL, OP_RR, OP_SWAP: begin
          cls_o.legal  = 1'b1;
          cls_o.has_wb = 1'b1;
          cls_o.upd_z  = 1'b1;
        end
        OP_SETC: begin
          cls_o.legal       = 1'b1;
          cls_o.force_c     = 1'b1;
          cls_o.force_c_val = 1'b1;
        end
        OP_CLRC: begin
          cls_o.legal   = 1'b1;
          cls_o.force_c = 1'b1;
        end
        default: cls_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage sequencer: accepts a request, runs the ALU for one
// cycle, captures result and flags, then writes back to the regfile.
// Build option ALU_EXEC_MUL_HI_EN: multiply also writes the high byte
// to dst+1 (WB_H). Without it, multiply writes only the low byte.
//
// state | meaning
// IDLE  | ready for a request, ALU held in reset
// EXEC  | ALU enabled for exactly one cycle, results captured
// WB_L  | writeback of low result byte to dst
// WB_H  | writeback of high multiply byte to dst+1 (option only)
module alu_exec
  import alu_pkg::*;
#(
  parameter int DST_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_exec_if.slave  bus,
  output logic       alu_rst_o,
  output logic       alu_enable_o,
  output logic [7:0] alu_operation_o,
  output logic [7:0] alu_op1_o,
  output logic [7:0] alu_op2_o,
  output logic       alu_cpu_carry_o,
  input  logic [7:0] alu_result_l_i,
  input  logic [7:0] alu_result_h_i,
  input  logic       alu_carry_i,
  input  logic       alu_zero_i,
  input  logic       alu_sign_i,
  output logic       flag_c_o,
  output logic       flag_z_o,
  output logic       flag_s_o,
  output logic       err_o
);

  state_e           state_q;
  logic [7:0]       op_q, a_q, b_q;
  logic [DST_W-1:0] dst_q;
  logic             flag_c_q, flag_z_q, flag_s_q;
  logic             flag_c_d, flag_z_d, flag_s_d;
  logic             req_ready_q, wb_valid_q, err_q;
  logic             alu_enable_q, alu_rst_q;
  logic [DST_W-1:0] wb_addr_q;
  logic [7:0]       wb_data_q;
  logic             go_hi;
  op_class_t        cls;

  alu_exec_decode u_decode (
    .op_i  (op_q),
    .cls_o (cls)
  );

`ifdef ALU_EXEC_MUL_HI_EN
  logic [7:0] res_h_q;
  assign go_hi = cls.is_mul;
`else
  logic unused_hi;
  assign go_hi     = 1'b0;
  assign unused_hi = ^{alu_result_h_i, cls.is_mul};
`endif

  // Flag values to commit at the end of EXEC; illegal ops decode to no effect
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_s_d = flag_s_q;
    if (cls.force_c)     flag_c_d = cls.force_c_val;
    else if (cls.upd_c)  flag_c_d = alu_carry_i;
    if (cls.upd_z)       flag_z_d = alu_zero_i;
    if (cls.upd_s)       flag_s_d = alu_sign_i;
  end

  // Sequencer FSM with registered handshake, ALU control and flag outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      dst_q        <= '0;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      flag_s_q     <= 1'b0;
      req_ready_q  <= 1'b1;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
      alu_enable_q <= 1'b0;
      alu_rst_q    <= 1'b1;
`ifdef ALU_EXEC_MUL_HI_EN
      res_h_q      <= '0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q         <= bus.req_op;
            a_q          <= bus.req_a;
            b_q          <= bus.req_b;
            dst_q        <= bus.req_dst;
            req_ready_q  <= 1'b0;
            alu_enable_q <= 1'b1;
            alu_rst_q    <= 1'b0;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          alu_enable_q <= 1'b0;
          alu_rst_q    <= 1'b1;
          flag_c_q     <= flag_c_d;
          flag_z_q     <= flag_z_d;
          flag_s_q     <= flag_s_d;
`ifdef ALU_EXEC_MUL_HI_EN
          res_h_q      <= alu_result_h_i;
`endif
          if (!cls.legal) begin
            err_q       <= 1'b1;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else if (cls.has_wb) begin
            wb_valid_q <= 1'b1;
            wb_addr_q  <= dst_q;
            wb_data_q  <= alu_result_l_i;
            state_q    <= WB_L;
          end else begin
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        WB_L: begin
          if (bus.wb_ready) begin
            if (go_hi) begin
`ifdef ALU_EXEC_MUL_HI_EN
              wb_addr_q <= dst_q + DST_W'(1);
              wb_data_q <= res_h_q;
`endif
              state_q   <= WB_H;
            end else begin
              wb_valid_q  <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end
`ifdef ALU_EXEC_MUL_HI_EN
        WB_H: begin
          if (bus.wb_ready) begin
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
`endif
        default: begin
          wb_valid_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          alu_enable_q <= 1'b0;
          alu_rst_q    <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.wb_data     = wb_data_q;
  assign alu_rst_o       = alu_rst_q;
  assign alu_enable_o    = alu_enable_q;
  assign alu_operation_o = op_q;
  assign alu_op1_o       = a_q;
  assign alu_op2_o       = b_q;
  assign alu_cpu_carry_o = flag_c_q;
  assign flag_c_o        = flag_c_q;
  assign flag_z_o        = flag_z_q;
  assign flag_s_o        = flag_s_q;
  assign err_o           = err_q;

endmodule
